// File: rtl/traceback_unit.sv
// Affine-gap traceback walker: reads direction words from the array's RAMs,
// walks back from (tb_x, tb_y) and streams one alignment op per step.
module traceback_unit #(
  parameter int N                = 4,
  parameter int DIRECTION_WIDTH  = 5,
  parameter int ADDRESS_WIDTH    = 10,
  parameter int MEM_AMOUNT_WIDTH = 4,
  parameter int LOG_N            = 2,
  parameter int RD_LAT           = 1
) (
  input  logic                          clk,
  input  logic                          reset_i,
  input  logic                          start,
  input  logic                          sys_busy,
  input  logic [ADDRESS_WIDTH-1:0]      tb_x,
  input  logic [ADDRESS_WIDTH-1:0]      tb_y,
  output logic [MEM_AMOUNT_WIDTH-1:0]   mem_block_num,
  output logic [ADDRESS_WIDTH-1:0]      row_num,
  input  logic [N*DIRECTION_WIDTH-1:0]  row_k0,
  output logic                          op_valid,
  input  logic                          op_ready,
  output logic [1:0]                    op,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [ADDRESS_WIDTH-1:0]      start_x,
  output logic [ADDRESS_WIDTH-1:0]      start_y,
  output logic [ADDRESS_WIDTH-1:0]      op_cnt
);
  localparam logic [1:0] OP_M = 2'd0, OP_I = 2'd1, OP_D = 2'd2;
  localparam logic [ADDRESS_WIDTH-1:0] ONE = ADDRESS_WIDTH'(1);
  localparam logic [7:0] WLAST = 8'(RD_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DECODE, S_FIN} state_t;
  typedef enum logic [2:0] {G_H, G_E, G_EH, G_F, G_FH} gstate_t;

  state_t r_state, w_state_nx;
  gstate_t r_g, w_gnext;
  logic [ADDRESS_WIDTH-1:0] r_x, r_y, w_xm1, w_nx, w_ny;
  logic [DIRECTION_WIDTH-1:0] r_w;
  logic [7:0] r_wcnt;
  logic w_ld, w_dx, w_dy, w_stop, w_bad, w_dec_go, w_edge, w_start_ok;
  logic [1:0] w_opc;
  logic [DIRECTION_WIDTH-1:0] w_lanes [N];
  logic [LOG_N-1:0] w_lane;

  for (genvar j = 0; j < N; j++) begin : g_lane
    assign w_lanes[j] = row_k0[j*DIRECTION_WIDTH +: DIRECTION_WIDTH];
  end

  assign w_xm1      = r_x - ONE;
  assign w_lane     = w_xm1[LOG_N-1:0];
  assign w_nx       = r_x - {{(ADDRESS_WIDTH-1){1'b0}}, w_dx};
  assign w_ny       = r_y - {{(ADDRESS_WIDTH-1){1'b0}}, w_dy};
  assign w_edge     = (w_nx == '0) || (w_ny == '0);
  assign w_dec_go   = (r_state == S_DECODE) && (!op_valid || op_ready);
  assign w_start_ok = start && !sys_busy;

  // Decode the latched word against the current walk state.
  always_comb begin
    w_ld = 1'b0; w_opc = OP_M; w_dx = 1'b0; w_dy = 1'b0;
    w_gnext = r_g; w_stop = 1'b0; w_bad = 1'b0;
    case (r_g)
      G_H: case (r_w[2:0])
        3'd0: begin w_ld = 1'b1; w_opc = OP_M; w_dx = 1'b1; w_dy = 1'b1; w_gnext = G_H; end
        3'd1: begin w_ld = 1'b1; w_opc = OP_I; w_dx = 1'b1; w_gnext = r_w[3] ? G_E  : G_H; end
        3'd2: begin w_ld = 1'b1; w_opc = OP_I; w_dx = 1'b1; w_gnext = r_w[4] ? G_EH : G_H; end
        3'd3: begin w_ld = 1'b1; w_opc = OP_D; w_dy = 1'b1; w_gnext = r_w[3] ? G_F  : G_H; end
        3'd4: begin w_ld = 1'b1; w_opc = OP_D; w_dy = 1'b1; w_gnext = r_w[4] ? G_FH : G_H; end
        3'd5: w_stop = 1'b1;
        default: begin w_stop = 1'b1; w_bad = 1'b1; end
      endcase
      G_E:  begin w_ld = 1'b1; w_opc = OP_I; w_dx = 1'b1; w_gnext = r_w[3] ? G_E  : G_H; end
      G_EH: begin w_ld = 1'b1; w_opc = OP_I; w_dx = 1'b1; w_gnext = r_w[4] ? G_EH : G_H; end
      G_F:  begin w_ld = 1'b1; w_opc = OP_D; w_dy = 1'b1; w_gnext = r_w[3] ? G_F  : G_H; end
      G_FH: begin w_ld = 1'b1; w_opc = OP_D; w_dy = 1'b1; w_gnext = r_w[4] ? G_FH : G_H; end
      default: begin w_stop = 1'b1; w_bad = 1'b1; end
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:   if (w_start_ok) w_state_nx = (tb_x == '0 || tb_y == '0) ? S_FIN : S_ISSUE;
      S_ISSUE:  w_state_nx = S_WAIT;
      S_WAIT:   if (r_wcnt == WLAST) w_state_nx = S_DECODE;
      S_DECODE: if (w_dec_go) w_state_nx = (w_stop || w_edge) ? S_FIN : S_ISSUE;
      S_FIN:    if (!op_valid) w_state_nx = S_IDLE;
      default:  w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_x <= '0; r_y <= '0; r_g <= G_H; r_w <= '0; r_wcnt <= '0;
      mem_block_num <= '0; row_num <= '0; op_valid <= 1'b0; op <= OP_M;
      busy <= 1'b0; done <= 1'b0; err <= 1'b0;
      start_x <= '0; start_y <= '0; op_cnt <= '0;
    end else begin
      done <= 1'b0;
      if (op_valid && op_ready) op_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_start_ok) begin
          r_x <= tb_x; r_y <= tb_y; r_g <= G_H;
          op_cnt <= '0; err <= 1'b0; busy <= 1'b1;
        end
        S_ISSUE: begin
          mem_block_num <= MEM_AMOUNT_WIDTH'(w_xm1 >> LOG_N);
          row_num       <= r_y - ONE;
          r_wcnt        <= '0;
        end
        S_WAIT: begin
          if (r_wcnt == WLAST) r_w <= w_lanes[w_lane];
          else                 r_wcnt <= r_wcnt + 8'd1;
        end
        S_DECODE: if (w_dec_go) begin
          if (w_ld) begin
            op_valid <= 1'b1; op <= w_opc;
            r_x <= w_nx; r_y <= w_ny; r_g <= w_gnext;
            if (op_cnt != '1) op_cnt <= op_cnt + ONE;
          end
          if (w_bad) err <= 1'b1;
        end
        S_FIN: if (!op_valid) begin
          // Last move stepped past the first aligned cell, so add one back.
          start_x <= r_x + ONE; start_y <= r_y + ONE;
          done <= 1'b1; busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_traceback_unit.sv
// Bench for traceback_unit: RAM model plus an op scoreboard fed per walk.
module tb_traceback_unit;
  localparam int N = 4, DW = 5, AW = 10, MAW = 4, LOG_N = 2;

  logic clk = 1'b0;
  logic reset_i, start, sys_busy, op_ready;
  logic [AW-1:0] tb_x, tb_y, row_num, start_x, start_y, op_cnt;
  logic [MAW-1:0] mem_block_num;
  logic [N*DW-1:0] row_k0;
  logic op_valid, busy, done, err;
  logic [1:0] op;

  logic [N*DW-1:0] ram [16][16];
  assign row_k0 = ram[mem_block_num][row_num[3:0]];

  typedef struct packed { logic cb; logic [3:0] blk; logic [1:0] op; } exp_t;
  exp_t exp_q[$];
  int checks = 0, failures = 0;

  always #5 clk = ~clk;

  traceback_unit #(.N(N), .DIRECTION_WIDTH(DW), .ADDRESS_WIDTH(AW),
                   .MEM_AMOUNT_WIDTH(MAW), .LOG_N(LOG_N), .RD_LAT(1)) dut (
    .clk(clk), .reset_i(reset_i), .start(start), .sys_busy(sys_busy),
    .tb_x(tb_x), .tb_y(tb_y), .mem_block_num(mem_block_num), .row_num(row_num),
    .row_k0(row_k0), .op_valid(op_valid), .op_ready(op_ready), .op(op),
    .busy(busy), .done(done), .err(err), .start_x(start_x), .start_y(start_y),
    .op_cnt(op_cnt));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: every transfer pops the next expected op.
  always @(negedge clk) begin
    if (op_valid && op_ready) begin
      if (exp_q.size() == 0) chk("op_extra", 1, 0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("op", op, e.op);
        if (e.cb) chk("blk", mem_block_num, e.blk);
      end
    end
  end

  task automatic clr();
    for (int b = 0; b < 16; b++)
      for (int r = 0; r < 16; r++) ram[b][r] = '0;
  endtask

  task automatic setc(input int x, input int y, input logic [4:0] w);
    ram[(x-1) >> LOG_N][y-1][((x-1) % N)*DW +: DW] = w;
  endtask

  task automatic push(input logic [1:0] o, input logic [3:0] b, input logic cb);
    exp_t e;
    e.op = o; e.blk = b; e.cb = cb;
    exp_q.push_back(e);
  endtask

  task automatic go(input int x, input int y);
    @(posedge clk); #1;
    tb_x = AW'(x); tb_y = AW'(y); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic fin(input string tag, input int sx, input int sy, input int cnt, input logic e);
    logic got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (done) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk({tag, "_done"}, got, 1);
    chk({tag, "_sx"}, start_x, sx);
    chk({tag, "_sy"}, start_y, sy);
    chk({tag, "_cnt"}, op_cnt, cnt);
    chk({tag, "_err"}, err, e);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_drain"}, exp_q.size(), 0);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, done, 0);
  endtask

  task automatic wait_valid(input string tag);
    logic got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (op_valid) begin got = 1'b1; break; end
      @(posedge clk); #1;
    end
    chk({tag, "_vld_to"}, got, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);      chk({tag, "_vld"}, op_valid, 0);
    chk({tag, "_op"}, op, 0);        chk({tag, "_cnt"}, op_cnt, 0);
    chk({tag, "_sx"}, start_x, 0);   chk({tag, "_sy"}, start_y, 0);
    chk({tag, "_blk"}, mem_block_num, 0); chk({tag, "_row"}, row_num, 0);
  endtask

  initial begin
    logic [1:0] snap_op;
    logic [AW-1:0] snap_row;
    reset_i = 1'b1; start = 1'b0; sys_busy = 1'b0; op_ready = 1'b1;
    tb_x = '0; tb_y = '0;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("rst");
    reset_i = 1'b0;

    // Pure diagonal from (5,3).
    push(2'd0, 4'd1, 1'b1); push(2'd0, 4'd0, 1'b1); push(2'd0, 4'd0, 1'b1);
    go(5, 3);
    chk("diag_busy", busy, 1);
    fin("diag", 3, 1, 3, 1'b0);

    // Short horizontal gap crossing a block boundary.
    clr();
    setc(6, 6, 5'b01001); setc(5, 6, 5'b01000); setc(4, 6, 5'b00000); setc(3, 6, 5'd5);
    push(2'd1, 4'd1, 1'b1); push(2'd1, 4'd1, 1'b1); push(2'd1, 4'd0, 1'b1);
    go(6, 6);
    fin("hgap", 4, 7, 3, 1'b0);

    // Long vertical gap.
    clr();
    setc(2, 9, 5'b10100); setc(2, 8, 5'b10000); setc(2, 7, 5'b10000);
    setc(2, 6, 5'b00000); setc(2, 5, 5'd5);
    repeat (4) push(2'd2, 4'd0, 1'b1);
    go(2, 9);
    fin("vgap", 3, 6, 4, 1'b0);

    // Same walk with the first op held for 7 cycles.
    repeat (4) push(2'd2, 4'd0, 1'b0);
    op_ready = 1'b0;
    go(2, 9);
    wait_valid("bp");
    snap_op = op;
    chk("bp_op", snap_op, 2);
    snap_row = row_num;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      chk("bp_vld", op_valid, 1);
      chk("bp_hold", op, snap_op);
      if (i == 2) snap_row = row_num;
      if (i > 2) chk("bp_row", row_num, snap_row);
    end
    chk("bp_row_at", snap_row, 7);
    op_ready = 1'b1;
    fin("bp", 3, 6, 4, 1'b0);

    // Zero coordinate goes straight to completion.
    go(0, 5);
    fin("zero", 1, 6, 0, 1'b0);

    // Illegal source code at the first cell.
    clr();
    setc(3, 3, 5'd7);
    go(3, 3);
    fin("ill", 4, 4, 0, 1'b1);
    sys_busy = 1'b1;
    go(2, 2);
    sys_busy = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      chk("sysb_busy", busy, 0);
    end
    chk("sysb_err", err, 1);

    // A start while busy must not disturb the active walk.
    clr();
    for (int i = 0; i < 5; i++) push(2'd0, 4'd0, 1'b0);
    op_ready = 1'b0;
    go(5, 5);
    chk("bsy_err_clr", err, 0);
    go(2, 2);
    op_ready = 1'b1;
    fin("bsy", 1, 1, 5, 1'b0);

    // Reset in WAIT, then a one-cell walk.
    go(5, 3);
    @(posedge clk); #1;
    chk("wait_row", row_num, 2);
    chk("wait_blk", mem_block_num, 1);
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    chk_zero("mrst");
    repeat (12) begin
      @(posedge clk); #1;
      chk("mrst_idle", busy | done | op_valid, 0);
    end
    push(2'd0, 4'd0, 1'b1);
    go(1, 1);
    fin("one", 1, 1, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
